// File: rtl/pipe_pkg.sv
// Shared types and helpers for the pipeline stall/flush controller.
package pipe_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      HALT     = 2'd2
   } state_e;

   // Wide enough to hold TIMEOUT-1 with headroom.
   function automatic int wait_w(input int timeout);
      return $clog2(timeout) + 1;
   endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear taking priority.
module sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush controller for the RV32 5-stage pipeline, with dmem
// timeout detection and saturating stall/flush performance counters.
module pipe_ctrl #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             hazard,
   input  logic             ex_branch_taken,
   input  logic             imem_ready,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   input  logic             clr_cnt,
   output logic             pc_wr,
   output logic             ifid_wr,
   output logic             ifid_flush,
   output logic             idex_wr,
   output logic             idex_flush,
   output logic             exmem_wr,
   output logic             memwb_flush,
   output logic             bus_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   import pipe_pkg::*;

   localparam int WW = wait_w(TIMEOUT);

   state_e          state_q, state_d;
   logic [WW-1:0]   wait_cnt_q, wait_cnt_d;
   logic            bus_err_q, bus_err_d;

   logic mem_stall;
   logic r_halt, r_mem, r_br, r_hz, r_im;
   logic pc_wr_c, ifid_wr_c, ifid_flush_c;
   logic idex_wr_c, idex_flush_c, exmem_wr_c, memwb_flush_c;
   logic stall_ev, flush_ev;

   assign mem_stall = dmem_req & ~dmem_ready;

   // One-hot rule selects; earlier rules mask later ones.
   assign r_halt = (state_q == HALT);
   assign r_mem  = ~r_halt & mem_stall;
   assign r_br   = ~r_halt & ~mem_stall & ex_branch_taken;
   assign r_hz   = ~r_halt & ~mem_stall & ~ex_branch_taken & hazard;
   assign r_im   = ~r_halt & ~mem_stall & ~ex_branch_taken & ~hazard
                   & ~imem_ready;

   always_comb begin
      pc_wr_c       = 1'b1;
      ifid_wr_c     = 1'b1;
      ifid_flush_c  = 1'b0;
      idex_wr_c     = 1'b1;
      idex_flush_c  = 1'b0;
      exmem_wr_c    = 1'b1;
      memwb_flush_c = 1'b0;
      unique case (1'b1)
         r_halt: begin
            pc_wr_c    = 1'b0;
            ifid_wr_c  = 1'b0;
            idex_wr_c  = 1'b0;
            exmem_wr_c = 1'b0;
         end
         r_mem: begin
            pc_wr_c       = 1'b0;
            ifid_wr_c     = 1'b0;
            idex_wr_c     = 1'b0;
            exmem_wr_c    = 1'b0;
            memwb_flush_c = 1'b1;
         end
         r_br: begin
            ifid_flush_c = 1'b1;
            idex_flush_c = 1'b1;
         end
         r_hz: begin
            pc_wr_c      = 1'b0;
            ifid_wr_c    = 1'b0;
            idex_flush_c = 1'b1;
         end
         r_im: begin
            pc_wr_c      = 1'b0;
            ifid_flush_c = 1'b1;
         end
         default: ;
      endcase
   end

   assign stall_ev = r_mem | r_hz | r_im;
   assign flush_ev = r_br;

   // Controls are held low for the whole reset window.
   assign pc_wr       = rst_n & pc_wr_c;
   assign ifid_wr     = rst_n & ifid_wr_c;
   assign ifid_flush  = rst_n & ifid_flush_c;
   assign idex_wr     = rst_n & idex_wr_c;
   assign idex_flush  = rst_n & idex_flush_c;
   assign exmem_wr    = rst_n & exmem_wr_c;
   assign memwb_flush = rst_n & memwb_flush_c;

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      bus_err_d  = bus_err_q;
      unique case (state_q)
         RUN: begin
            if (mem_stall) begin
               state_d    = MEM_WAIT;
               wait_cnt_d = WW'(1);
            end
         end
         MEM_WAIT: begin
            if (!mem_stall) begin
               state_d    = RUN;
               wait_cnt_d = '0;
            end else if (wait_cnt_q == WW'(TIMEOUT - 1)) begin
               state_d   = HALT;
               bus_err_d = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + WW'(1);
            end
         end
         HALT: ;
         default: begin
            state_d    = RUN;
            wait_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= RUN;
         wait_cnt_q <= '0;
         bus_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         bus_err_q  <= bus_err_d;
      end
   end

   assign bus_err = bus_err_q;

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (stall_ev),
      .clr   (clr_cnt),
      .cnt   (stall_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (flush_ev),
      .clr   (clr_cnt),
      .cnt   (flush_cnt)
   );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: rule priority, dmem timeout,
// reset behaviour and counter saturation/clear.
module tb_pipe_ctrl;

   localparam int TIMEOUT = 16;
   localparam int CNT_W   = 4;

   // {pc_wr, ifid_wr, ifid_flush, idex_wr, idex_flush, exmem_wr, memwb_flush}
   localparam logic [6:0] C_DEF  = 7'b1101010;
   localparam logic [6:0] C_MEM  = 7'b0000001;
   localparam logic [6:0] C_BR   = 7'b1111110;
   localparam logic [6:0] C_HZ   = 7'b0001110;
   localparam logic [6:0] C_IM   = 7'b0111010;
   localparam logic [6:0] C_ZERO = 7'b0000000;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             hazard, ex_branch_taken, imem_ready;
   logic             dmem_req, dmem_ready, clr_cnt;
   logic             pc_wr, ifid_wr, ifid_flush, idex_wr, idex_flush;
   logic             exmem_wr, memwb_flush, bus_err;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;
   logic [6:0]       ctl;

   int vectors    = 0;
   int miscompares = 0;

   pipe_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .hazard          (hazard),
      .ex_branch_taken (ex_branch_taken),
      .imem_ready      (imem_ready),
      .dmem_req        (dmem_req),
      .dmem_ready      (dmem_ready),
      .clr_cnt         (clr_cnt),
      .pc_wr           (pc_wr),
      .ifid_wr         (ifid_wr),
      .ifid_flush      (ifid_flush),
      .idex_wr         (idex_wr),
      .idex_flush      (idex_flush),
      .exmem_wr        (exmem_wr),
      .memwb_flush     (memwb_flush),
      .bus_err         (bus_err),
      .stall_cnt       (stall_cnt),
      .flush_cnt       (flush_cnt)
   );

   always #5 clk = ~clk;

   assign ctl = {pc_wr, ifid_wr, ifid_flush, idex_wr, idex_flush,
                 exmem_wr, memwb_flush};

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      hazard = 0; ex_branch_taken = 0; imem_ready = 1;
      dmem_req = 0; dmem_ready = 0; clr_cnt = 0;
   endtask

   // Advance one cycle; inputs change and outputs are sampled mid-low-phase.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   initial begin
      idle();
      rst_n  = 0;
      hazard = 1;
      #2;
      chk("rst_ctl", 32'(ctl), 32'(C_ZERO));
      chk("rst_stall", 32'(stall_cnt), 0);
      chk("rst_flush", 32'(flush_cnt), 0);
      chk("rst_buserr", 32'(bus_err), 0);
      tick();
      chk("rst_hold_ctl", 32'(ctl), 32'(C_ZERO));
      idle();
      rst_n = 1;
      #1;
      chk("rel_ctl", 32'(ctl), 32'(C_DEF));

      // Load-use: one bubble
      hazard = 1;
      #1;
      chk("hz_ctl", 32'(ctl), 32'(C_HZ));
      tick();
      hazard = 0;
      #1;
      chk("hz_stall", 32'(stall_cnt), 1);
      chk("hz_after_ctl", 32'(ctl), 32'(C_DEF));

      // Branch beats hazard
      hazard = 1; ex_branch_taken = 1;
      #1;
      chk("brhz_ctl", 32'(ctl), 32'(C_BR));
      tick();
      idle();
      #1;
      chk("brhz_flush", 32'(flush_cnt), 1);
      chk("brhz_stall", 32'(stall_cnt), 1);

      // Dmem wait with pending branch
      dmem_req = 1; dmem_ready = 0; ex_branch_taken = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("memw_ctl", 32'(ctl), 32'(C_MEM));
         tick();
      end
      chk("memw_stall", 32'(stall_cnt), 4);
      chk("memw_flush", 32'(flush_cnt), 1);
      dmem_ready = 1;
      #1;
      chk("memw_br_ctl", 32'(ctl), 32'(C_BR));
      tick();
      idle();
      #1;
      chk("memw_br_flush", 32'(flush_cnt), 2);
      chk("memw_br_buserr", 32'(bus_err), 0);

      // Fetch miss
      imem_ready = 0;
      #1;
      chk("im_ctl", 32'(ctl), 32'(C_IM));
      tick();
      idle();
      #1;
      chk("im_stall", 32'(stall_cnt), 5);

      // Hazard held across a dmem stall
      hazard = 1; dmem_req = 1;
      #1;
      chk("hzmem_ctl", 32'(ctl), 32'(C_MEM));
      tick();
      dmem_ready = 1;
      #1;
      chk("hzmem_rel_ctl", 32'(ctl), 32'(C_HZ));
      tick();
      idle();
      #1;
      chk("hzmem_stall", 32'(stall_cnt), 7);

      // Clear counters
      clr_cnt = 1;
      tick();
      clr_cnt = 0;
      #1;
      chk("clr_stall", 32'(stall_cnt), 0);
      chk("clr_flush", 32'(flush_cnt), 0);

      // TIMEOUT-1 stalls then ready: no halt
      dmem_req = 1;
      for (int i = 0; i < TIMEOUT - 1; i++) tick();
      chk("near_to_ctl", 32'(ctl), 32'(C_MEM));
      dmem_ready = 1;
      #1;
      chk("near_to_rel", 32'(ctl), 32'(C_DEF));
      tick();
      idle();
      #1;
      chk("near_to_buserr", 32'(bus_err), 0);
      chk("near_to_stall", 32'(stall_cnt), 15);

      clr_cnt = 1;
      tick();
      clr_cnt = 0;

      // Full timeout
      dmem_req = 1;
      for (int i = 0; i < 10; i++) tick();
      chk("to_stall10", 32'(stall_cnt), 10);
      for (int i = 0; i < TIMEOUT - 11; i++) tick();
      chk("to_pre_buserr", 32'(bus_err), 0);
      chk("to_pre_ctl", 32'(ctl), 32'(C_MEM));
      tick();
      chk("to_buserr", 32'(bus_err), 1);
      chk("to_halt_ctl", 32'(ctl), 32'(C_ZERO));
      chk("to_stall_sat", 32'(stall_cnt), 15);

      // HALT is absorbing and uncounted
      dmem_ready = 1; hazard = 1; clr_cnt = 1;
      tick();
      clr_cnt = 0;
      #1;
      chk("halt_clr", 32'(stall_cnt), 0);
      tick();
      chk("halt_nocount", 32'(stall_cnt), 0);
      chk("halt_ctl", 32'(ctl), 32'(C_ZERO));
      chk("halt_buserr", 32'(bus_err), 1);

      // Reset out of HALT, asynchronously mid-cycle
      #1;
      rst_n = 0;
      #1;
      chk("hrst_ctl", 32'(ctl), 32'(C_ZERO));
      chk("hrst_buserr", 32'(bus_err), 0);
      tick();
      idle();
      rst_n = 1;
      #1;
      chk("hrst_rel_ctl", 32'(ctl), 32'(C_DEF));

      // Saturation then clear-over-increment
      hazard = 1;
      for (int i = 0; i < 20; i++) tick();
      chk("sat_stall", 32'(stall_cnt), 15);
      clr_cnt = 1;
      tick();
      clr_cnt = 0;
      #1;
      chk("sat_clr", 32'(stall_cnt), 0);
      tick();
      chk("sat_inc", 32'(stall_cnt), 1);
      idle();

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipeline stall/flush controller for the RV32 5-stage core. Sits directly downstream of the load-use hazard detector.
- Consumes the detector's `hazard` flag, the EX-stage branch decision, and the instruction/data memory ready signals.
- Drives the write-enables and bubble/flush controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Also tracks data-memory wait time with a timeout, and keeps saturating stall/flush performance counters.

Parameters:
- TIMEOUT, 16, max consecutive dmem wait cycles before halt (≥2).
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- hazard  in  1  load-use hazard from the hazard detector (ID src == EX rd, EX is a load).
- ex_branch_taken  in  1  EX-stage branch/jump redirect this cycle.
- imem_ready  in  1  instruction fetch completes this cycle.
- dmem_req  in  1  MEM-stage instruction accesses data memory.
- dmem_ready  in  1  data access completes this cycle.
- clr_cnt  in  1  synchronous clear of both counters.
- pc_wr  out  1  PC register update enable.
- ifid_wr  out  1  IF/ID update enable.
- ifid_flush  out  1  IF/ID loads a bubble (NOP).
- idex_wr  out  1  ID/EX update enable.
- idex_flush  out  1  ID/EX loads a bubble.
- exmem_wr  out  1  EX/MEM update enable.
- memwb_flush  out  1  MEM/WB loads a bubble.
- bus_err  out  1  sticky dmem timeout flag.
- stall_cnt  out  CNT_W  stall cycles counted.
- flush_cnt  out  CNT_W  branch flushes counted.

Behaviour:
- Clock is `clk`. Reset is asynchronous, active-low (`rst_n`).
- Reset state: FSM = RUN, wait_cnt = 0, bus_err = 0, stall_cnt = 0, flush_cnt = 0.
- While rst_n = 0, every control output (wr and flush) is forced to 0.
- Control outputs are combinational from FSM state and current inputs, so they act in the same cycle, zero latency.
- mem_stall = dmem_req & ~dmem_ready.
- Priority, first match wins; any control not named takes its default (all wr = 1, all flush = 0):
  1. State HALT: all wr = 0, all flush = 0.
  2. mem_stall: pc_wr, ifid_wr, idex_wr, exmem_wr = 0; memwb_flush = 1. Any branch or hazard is held and re-evaluated when the stall ends.
  3. ex_branch_taken: pc_wr = 1, ifid_flush = 1, idex_flush = 1. `hazard` is ignored, because the ID instruction is squashed.
  4. hazard: pc_wr = 0, ifid_wr = 0, idex_flush = 1. Exactly one bubble per assertion of `hazard`.
  5. ~imem_ready: pc_wr = 0, ifid_flush = 1; later stages advance.
  6. Otherwise: defaults.
- Flush overrides wr for the same register; the flushed register loads a bubble.
- FSM states: RUN, MEM_WAIT, HALT.
  - RUN → MEM_WAIT when mem_stall. wait_cnt <= 1.
  - MEM_WAIT → RUN when dmem_ready or ~dmem_req. wait_cnt <= 0.
  - MEM_WAIT stays while mem_stall and wait_cnt < TIMEOUT-1. wait_cnt increments.
  - MEM_WAIT → HALT when mem_stall and wait_cnt == TIMEOUT-1. Thus TIMEOUT stalled cycles lead to HALT. bus_err <= 1.
  - HALT is absorbing; only rst_n leaves it.
- The stall controls in MEM_WAIT are identical to RUN.
- stall_cnt: +1 on each cycle where rule 2, 4 or 5 fires. HALT cycles are not counted.
- flush_cnt: +1 on each cycle where rule 3 fires.
- Both counters saturate at all-ones; no wrap.
- clr_cnt has priority over increment, and clears to 0 even in HALT.
- Reset asserted mid-stall or in HALT: immediate return to reset state. Outputs are 0 while reset is asserted.

Decomposition:
- Shared package `pipe_pkg`:
  - FSM state type {RUN, MEM_WAIT, HALT}.
  - wait-counter width constant, $clog2(TIMEOUT)+1.
- One sub-module `sat_counter` (CNT_W param; inc, clr inputs; saturating). Instantiated twice, for stall_cnt and flush_cnt.

Test Plan:
- Reset: assert rst_n = 0 mid-simulation with hazard = 1 → all controls 0, counters 0, bus_err 0. Release with idle inputs, imem_ready = 1 → pc_wr = ifid_wr = idex_wr = exmem_wr = 1, flushes 0.
- Load-use: hazard = 1 for one cycle → pc_wr = 0, ifid_wr = 0, idex_flush = 1 that cycle; stall_cnt = 1.
- Branch beats hazard: ex_branch_taken = 1 and hazard = 1 together → pc_wr = 1, ifid_flush = idex_flush = 1; flush_cnt = 1, stall_cnt unchanged.
- Dmem wait then branch:
  - dmem_req = 1, dmem_ready = 0 for 3 cycles with ex_branch_taken = 1 → 3 cycles of freeze with memwb_flush = 1, FSM in MEM_WAIT, stall_cnt = 3.
  - dmem_ready = 1 on the 4th cycle → branch flush fires, FSM returns to RUN.
- Timeout: dmem_req = 1, dmem_ready = 0 for 16 cycles (TIMEOUT = 16) → bus_err = 1 after the 16th edge, FSM in HALT, all wr = 0. Later dmem_ready = 1 does not exit HALT; rst_n does.
- Saturation/clear: with CNT_W = 4, 20 hazard cycles → stall_cnt = 15. Assert clr_cnt together with hazard → stall_cnt = 0 next cycle.
